// File: rtl/wb_bsplit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_bsplit_pkg
// Description : Shared types and constants for the Wishbone burst splitter.
//               Holds the splitter FSM state encoding and the default byte
//               increment applied between consecutive beats.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_bsplit_pkg;

    // Splitter sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,   // waiting for a burst request
        BEAT = 2'd1,   // downstream strobe active, waiting for ack/err
        GAP  = 2'd2    // one idle cycle between beats, cyc kept high
    } bsplit_state_t;

    // Default byte distance between beats (one 32-bit word).
    localparam int unsigned c_ADR_INC_DFLT = 4;

endpackage
`default_nettype wire

// File: rtl/wb_bsplit_tmo.sv
`default_nettype none
// ============================================================================
// Module      : wb_bsplit_tmo
// Description : Beat timeout counter for the Wishbone burst splitter. Only
//               present when WB_BSPLIT_TIMEOUT_EN is defined.
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   i_clear   in   restart the count (asserted on entry into BEAT)
//   i_run     in   count while high
//   o_expired out  counter has reached all-ones while running
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef WB_BSPLIT_TIMEOUT_EN
module wb_bsplit_tmo #(
    parameter int TMO_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    logic [TMO_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_run && !o_expired) begin
            // Saturate at all-ones so the expiry indication cannot wrap away.
            r_cnt <= r_cnt + TMO_W'(1);
        end
    end

    assign o_expired = i_run & (&r_cnt);

endmodule
`endif
`default_nettype wire

// File: rtl/wb_burst_splitter.sv
`default_nettype none
// ============================================================================
// Module      : wb_burst_splitter
// Description : Converts a Wishbone burst request (start address + length)
//               from the cache application port into a sequence of
//               single-beat Wishbone classic cycles. Per-beat ack, last-beat
//               lack and err are returned upstream.
//   mclk        in   clock
//   rst         in   synchronous active-high reset
//   wbs_*       upstream burst port (stb/adr/we/dat/sel/bl in,
//               dat/ack/lack/err out)
//   wbm_*       downstream classic port (cyc/stb/adr/we/dat/sel out,
//               dat/ack/err in)
//   Optional    : define WB_BSPLIT_TIMEOUT_EN to add a TMO_W-bit beat
//                 timeout that reports a stalled beat as an error.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_burst_splitter
    import wb_bsplit_pkg::*;
#(
    parameter int WB_AW   = 32,
    parameter int WB_DW   = 32,
    parameter int BL_W    = 10,
    parameter int ADR_INC = c_ADR_INC_DFLT,
    parameter int TMO_W   = 8
) (
    input  logic                 mclk,
    input  logic                 rst,
    // upstream (burst) side
    input  logic                 wbs_stb_i,
    input  logic [WB_AW-1:0]     wbs_adr_i,
    input  logic                 wbs_we_i,
    input  logic [WB_DW-1:0]     wbs_dat_i,
    input  logic [WB_DW/8-1:0]   wbs_sel_i,
    input  logic [BL_W-1:0]      wbs_bl_i,
    output logic [WB_DW-1:0]     wbs_dat_o,
    output logic                 wbs_ack_o,
    output logic                 wbs_lack_o,
    output logic                 wbs_err_o,
    // downstream (single-beat) side
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic [WB_AW-1:0]     wbm_adr_o,
    output logic                 wbm_we_o,
    output logic [WB_DW-1:0]     wbm_dat_o,
    output logic [WB_DW/8-1:0]   wbm_sel_o,
    input  logic [WB_DW-1:0]     wbm_dat_i,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i
);

    localparam int c_SW = WB_DW / 8;

    if (TMO_W < 1) begin : g_tmo_w_check
        $error("wb_burst_splitter: TMO_W must be at least 1");
    end

    bsplit_state_t     r_state, w_state_nxt;
    logic [BL_W-1:0]   r_bl, w_bl_nxt;       // latched burst length (>= 1)
    logic [BL_W-1:0]   r_cnt, w_cnt_nxt;     // beats completed so far
    logic              r_abort, w_abort_nxt; // upstream dropped stb mid-beat

    logic              w_cyc_nxt, w_stb_nxt, w_we_nxt;
    logic [WB_AW-1:0]  w_adr_nxt;
    logic [WB_DW-1:0]  w_dat_nxt, w_rdat_nxt;
    logic [c_SW-1:0]   w_sel_nxt;
    logic              w_ack_nxt, w_lack_nxt, w_err_nxt;

    logic              w_tmo_clr;
    logic              w_tmo_expired;
    logic              w_beat_err;
    logic              w_last;
    logic              w_abort_now;

`ifdef WB_BSPLIT_TIMEOUT_EN
    wb_bsplit_tmo #(
        .TMO_W     (TMO_W)
    ) u_tmo (
        .clk       (mclk),
        .rst       (rst),
        .i_clear   (w_tmo_clr),
        .i_run     (r_state == BEAT),
        .o_expired (w_tmo_expired)
    );
`else
    // Without the timeout a beat waits for the slave indefinitely.
    assign w_tmo_expired = 1'b0;
`endif

    // A stalled beat is reported exactly like a slave error.
    assign w_beat_err  = wbm_err_i | w_tmo_expired;
    assign w_last      = (r_cnt == (r_bl - BL_W'(1)));
    assign w_abort_now = r_abort | ~wbs_stb_i;

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_bl_nxt    = r_bl;
        w_cnt_nxt   = r_cnt;
        w_abort_nxt = r_abort;
        w_cyc_nxt   = wbm_cyc_o;
        w_stb_nxt   = wbm_stb_o;
        w_adr_nxt   = wbm_adr_o;
        w_we_nxt    = wbm_we_o;
        w_dat_nxt   = wbm_dat_o;
        w_sel_nxt   = wbm_sel_o;
        w_rdat_nxt  = wbs_dat_o;
        w_ack_nxt   = 1'b0;
        w_lack_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_tmo_clr   = 1'b0;

        case (r_state)
            IDLE: begin
                // The requester still holds stb during the lack/err cycle of
                // the previous burst; that cycle must not start a new one.
                if (wbs_stb_i && !wbs_lack_o) begin
                    w_state_nxt = BEAT;
                    w_cyc_nxt   = 1'b1;
                    w_stb_nxt   = 1'b1;
                    w_adr_nxt   = wbs_adr_i;
                    w_we_nxt    = wbs_we_i;
                    w_dat_nxt   = wbs_dat_i;
                    w_sel_nxt   = wbs_sel_i;
                    w_bl_nxt    = (wbs_bl_i == '0) ? BL_W'(1) : wbs_bl_i;
                    w_cnt_nxt   = '0;
                    w_abort_nxt = 1'b0;
                    w_tmo_clr   = 1'b1;
                end
            end

            BEAT: begin
                w_abort_nxt = w_abort_now;
                if (w_beat_err || wbm_ack_i) begin
                    if (w_abort_now) begin
                        // Requester has gone away: finish the beat silently.
                        w_state_nxt = IDLE;
                        w_cyc_nxt   = 1'b0;
                        w_stb_nxt   = 1'b0;
                    end else if (w_beat_err) begin
                        // Error wins over a simultaneous ack.
                        w_state_nxt = IDLE;
                        w_cyc_nxt   = 1'b0;
                        w_stb_nxt   = 1'b0;
                        w_err_nxt   = 1'b1;
                        w_lack_nxt  = 1'b1;
                    end else begin
                        w_rdat_nxt  = wbm_dat_i;
                        w_ack_nxt   = 1'b1;
                        w_cnt_nxt   = r_cnt + BL_W'(1);
                        w_adr_nxt   = wbm_adr_o + WB_AW'(ADR_INC);
                        w_stb_nxt   = 1'b0;
                        if (w_last) begin
                            w_state_nxt = IDLE;
                            w_cyc_nxt   = 1'b0;
                            w_lack_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = GAP;
                        end
                    end
                end
            end

            GAP: begin
                // The requester sees wbs_ack_o during this cycle and must
                // present the next write data before its end.
                if (!wbs_stb_i) begin
                    w_state_nxt = IDLE;
                    w_cyc_nxt   = 1'b0;
                end else begin
                    w_state_nxt = BEAT;
                    w_stb_nxt   = 1'b1;
                    w_dat_nxt   = wbs_dat_i;
                    w_tmo_clr   = 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_cyc_nxt   = 1'b0;
                w_stb_nxt   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge mclk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_bl       <= '0;
            r_cnt      <= '0;
            r_abort    <= 1'b0;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_adr_o  <= '0;
            wbm_we_o   <= 1'b0;
            wbm_dat_o  <= '0;
            wbm_sel_o  <= '0;
            wbs_dat_o  <= '0;
            wbs_ack_o  <= 1'b0;
            wbs_lack_o <= 1'b0;
            wbs_err_o  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bl       <= w_bl_nxt;
            r_cnt      <= w_cnt_nxt;
            r_abort    <= w_abort_nxt;
            wbm_cyc_o  <= w_cyc_nxt;
            wbm_stb_o  <= w_stb_nxt;
            wbm_adr_o  <= w_adr_nxt;
            wbm_we_o   <= w_we_nxt;
            wbm_dat_o  <= w_dat_nxt;
            wbm_sel_o  <= w_sel_nxt;
            wbs_dat_o  <= w_rdat_nxt;
            wbs_ack_o  <= w_ack_nxt;
            wbs_lack_o <= w_lack_nxt;
            wbs_err_o  <= w_err_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_burst_splitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_burst_splitter
// Description : Directed self-checking bench for wb_burst_splitter. A simple
//               downstream slave acks one cycle after seeing a strobe
//               (optionally erroring on a chosen beat, or never answering)
//               and logs every downstream beat. Read data returned by the
//               slave is the beat address XOR 0x5A5A_0000.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_burst_splitter;

    logic        mclk;
    logic        rst;
    logic        wbs_stb_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_we_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic [9:0]  wbs_bl_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic        wbs_lack_o;
    logic        wbs_err_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [31:0] wbm_adr_o;
    logic        wbm_we_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    wb_burst_splitter dut (
        .mclk       (mclk),
        .rst        (rst),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_bl_i   (wbs_bl_i),
        .wbs_dat_o  (wbs_dat_o),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_lack_o (wbs_lack_o),
        .wbs_err_o  (wbs_err_o),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_ack_i  (wbm_ack_i),
        .wbm_err_i  (wbm_err_i)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // ---------------- downstream slave model ----------------
    int          slv_err_at = -1;  // log index of the beat that gets err
    logic        slv_silent = 1'b0;
    logic [31:0] dn_adr[$];
    logic [31:0] dn_dat[$];
    logic [3:0]  dn_sel[$];
    logic        dn_we[$];

    initial begin
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = '0;
    end

    always @(posedge mclk) begin
        wbm_ack_i <= 1'b0;
        wbm_err_i <= 1'b0;
        if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !wbm_err_i && !slv_silent) begin
            if (dn_adr.size() == slv_err_at) wbm_err_i <= 1'b1;
            else                              wbm_ack_i <= 1'b1;
            wbm_dat_i <= wbm_adr_o ^ 32'h5A5A_0000;
            dn_adr.push_back(wbm_adr_o);
            dn_dat.push_back(wbm_dat_o);
            dn_sel.push_back(wbm_sel_o);
            dn_we.push_back(wbm_we_o);
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dn_adr_at(input int i);
        return (i < dn_adr.size()) ? dn_adr[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] dn_dat_at(input int i);
        return (i < dn_dat.size()) ? dn_dat[i] : 32'hDEAD_DEAD;
    endfunction

    // ---------------- upstream driver ----------------
    logic [31:0] wr_data [0:7];
    logic [31:0] rdat    [0:7];
    int          n_ack, n_lack, n_err, lack_at, ncyc;
    logic        errlack, ackerr, cyc_after, timed_out;

    // Issue one burst and follow it to lack/err, supplying the next write
    // word whenever an ack is seen; stb is released in the lack/err cycle.
    task automatic do_burst(input logic [31:0] adr, input logic we,
                            input logic [9:0] bl, input logic [3:0] sel,
                            input int budget);
        int widx;
        n_ack = 0; n_lack = 0; n_err = 0; lack_at = -1; ncyc = 0;
        errlack = 1'b0; ackerr = 1'b0; cyc_after = 1'b1; timed_out = 1'b1;
        widx = 0;
        for (int i = 0; i < 8; i++) rdat[i] = 32'hDEAD_DEAD;
        @(negedge mclk);
        wbs_adr_i = adr; wbs_we_i = we; wbs_bl_i = bl; wbs_sel_i = sel;
        wbs_dat_i = wr_data[0];
        wbs_stb_i = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge mclk);
            ncyc++;
            if (wbs_ack_o && wbs_err_o) ackerr = 1'b1;
            if (wbs_ack_o) begin
                if (n_ack < 8) rdat[n_ack] = wbs_dat_o;
                n_ack++;
                if (widx < 7) widx++;
                wbs_dat_i = wr_data[widx];
            end
            if (wbs_lack_o) begin
                n_lack++;
                lack_at = n_ack;
            end
            if (wbs_err_o) begin
                n_err++;
                errlack = wbs_lack_o;
            end
            if (wbs_lack_o || wbs_err_o) begin
                timed_out = 1'b0;
                cyc_after = wbm_cyc_o;
                break;
            end
        end
        wbs_stb_i = 1'b0;
        repeat (4) @(negedge mclk);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ctl"}, {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbs_ack_o, wbs_lack_o, wbs_err_o}, 6'b0);
        chk({tag, "_adr"}, wbm_adr_o, 32'h0);
        chk({tag, "_dat"}, {wbm_dat_o, wbs_dat_o}, 64'h0);
        chk({tag, "_sel"}, wbm_sel_o, 4'h0);
    endtask

    int base;
    int seen;

    initial begin
        rst = 1'b1;
        wbs_stb_i = 1'b0; wbs_adr_i = '0; wbs_we_i = 1'b0;
        wbs_dat_i = '0; wbs_sel_i = '0; wbs_bl_i = '0;
        for (int i = 0; i < 8; i++) wr_data[i] = '0;

        // ---- reset state ----
        repeat (3) @(negedge mclk);
        chk_idle_outputs("reset");
        rst = 1'b0;
        @(negedge mclk);

        // ---- read burst: 0x100, bl=4 ----
        base = dn_adr.size();
        do_burst(32'h0000_0100, 1'b0, 10'd4, 4'hF, 60);
        chk("rd_done", timed_out, 1'b0);
        chk("rd_nbeats", dn_adr.size() - base, 4);
        chk("rd_adr0", dn_adr_at(base + 0), 32'h0000_0100);
        chk("rd_adr1", dn_adr_at(base + 1), 32'h0000_0104);
        chk("rd_adr2", dn_adr_at(base + 2), 32'h0000_0108);
        chk("rd_adr3", dn_adr_at(base + 3), 32'h0000_010C);
        chk("rd_nack", n_ack, 4);
        chk("rd_dat0", rdat[0], 32'h5A5A_0100);
        chk("rd_dat1", rdat[1], 32'h5A5A_0104);
        chk("rd_dat2", rdat[2], 32'h5A5A_0108);
        chk("rd_dat3", rdat[3], 32'h5A5A_010C);
        chk("rd_nlack", n_lack, 1);
        chk("rd_lack_with_4th", lack_at, 4);
        chk("rd_nerr", n_err, 0);
        chk("rd_cyc_low", cyc_after, 1'b0);
        chk("rd_cyc_idle", {wbm_cyc_o, wbm_stb_o}, 2'b00);

        // ---- write burst: 0x400, bl=3, sel=0110 ----
        wr_data[0] = 32'h0000_00A0;
        wr_data[1] = 32'h0000_00B1;
        wr_data[2] = 32'h0000_00C2;
        wr_data[3] = 32'hFFFF_FFFF;
        base = dn_adr.size();
        do_burst(32'h0000_0400, 1'b1, 10'd3, 4'b0110, 60);
        chk("wr_nbeats", dn_adr.size() - base, 3);
        chk("wr_dat0", dn_dat_at(base + 0), 32'h0000_00A0);
        chk("wr_dat1", dn_dat_at(base + 1), 32'h0000_00B1);
        chk("wr_dat2", dn_dat_at(base + 2), 32'h0000_00C2);
        chk("wr_adr1", dn_adr_at(base + 1), 32'h0000_0404);
        chk("wr_adr2", dn_adr_at(base + 2), 32'h0000_0408);
        for (int i = 0; i < 3; i++) begin
            if (base + i < dn_sel.size()) begin
                chk("wr_sel", dn_sel[base + i], 4'b0110);
                chk("wr_we", dn_we[base + i], 1'b1);
            end
        end
        chk("wr_nack", n_ack, 3);
        chk("wr_lack_with_3rd", lack_at, 3);
        for (int i = 0; i < 8; i++) wr_data[i] = '0;

        // ---- error on beat 3 of an 8-beat burst ----
        base = dn_adr.size();
        slv_err_at = base + 2;
        do_burst(32'h0000_0500, 1'b0, 10'd8, 4'hF, 60);
        slv_err_at = -1;
        chk("err_nack", n_ack, 2);
        chk("err_nerr", n_err, 1);
        chk("err_with_lack", errlack, 1'b1);
        chk("err_nlack", n_lack, 1);
        chk("err_no_ack_with_err", ackerr, 1'b0);
        chk("err_cyc_low", cyc_after, 1'b0);
        chk("err_no_more_stb", dn_adr.size() - base, 3);

        // ---- bl=0 and bl=1 at the top of the address space ----
        base = dn_adr.size();
        do_burst(32'hFFFF_FFFC, 1'b0, 10'd0, 4'hF, 40);
        chk("bl0_nbeats", dn_adr.size() - base, 1);
        chk("bl0_adr", dn_adr_at(base), 32'hFFFF_FFFC);
        chk("bl0_ack_lack", {n_ack[7:0], lack_at[7:0]}, 16'h0101);
        chk("bl0_dat", rdat[0], 32'hA5A5_FFFC);

        base = dn_adr.size();
        do_burst(32'hFFFF_FFFC, 1'b0, 10'd1, 4'hF, 40);
        chk("bl1_nbeats", dn_adr.size() - base, 1);
        chk("bl1_ack_lack", {n_ack[7:0], lack_at[7:0]}, 16'h0101);

        // ---- 2-beat burst wrapping the address ----
        base = dn_adr.size();
        do_burst(32'hFFFF_FFFC, 1'b0, 10'd2, 4'hF, 40);
        chk("wrap_nbeats", dn_adr.size() - base, 2);
        chk("wrap_adr1", dn_adr_at(base + 1), 32'h0000_0000);
        chk("wrap_dat1", rdat[1], 32'h5A5A_0000);
        chk("wrap_lack", lack_at, 2);

        // ---- abort: stb dropped while the first beat is outstanding ----
        base = dn_adr.size();
        @(negedge mclk);
        wbs_adr_i = 32'h0000_0600; wbs_we_i = 1'b0; wbs_bl_i = 10'd4;
        wbs_sel_i = 4'hF; wbs_stb_i = 1'b1;
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(negedge mclk);
            if (wbm_stb_o) seen = 1;
        end
        chk("abort_stb_seen", seen, 1);
        wbs_stb_i = 1'b0;
        n_ack = 0; n_lack = 0; n_err = 0;
        repeat (6) begin
            @(negedge mclk);
            if (wbs_ack_o)  n_ack++;
            if (wbs_lack_o) n_lack++;
            if (wbs_err_o)  n_err++;
        end
        chk("abort_no_resp", {n_ack[7:0], n_lack[7:0], n_err[7:0]}, 24'h0);
        chk("abort_cyc_low", wbm_cyc_o, 1'b0);
        chk("abort_nbeats", dn_adr.size() - base, 1);

        // ---- reset during beat 2 of 4, then a fresh 2-beat burst ----
        @(negedge mclk);
        wbs_adr_i = 32'h0000_0200; wbs_we_i = 1'b0; wbs_bl_i = 10'd4;
        wbs_sel_i = 4'hF; wbs_stb_i = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge mclk);
            if (wbm_stb_o && wbm_adr_o == 32'h0000_0204) seen = 1;
        end
        chk("rstmid_beat2_seen", seen, 1);
        rst = 1'b1;
        wbs_stb_i = 1'b0;
        @(negedge mclk);
        chk_idle_outputs("rstmid");
        rst = 1'b0;
        base = dn_adr.size();
        do_burst(32'h0000_0300, 1'b0, 10'd2, 4'hF, 40);
        chk("post_rst_nack", n_ack, 2);
        chk("post_rst_lack", lack_at, 2);
        chk("post_rst_adr0", dn_adr_at(base + 0), 32'h0000_0300);
        chk("post_rst_adr1", dn_adr_at(base + 1), 32'h0000_0304);
        chk("post_rst_dat1", rdat[1], 32'h5A5A_0304);

`ifdef WB_BSPLIT_TIMEOUT_EN
        // ---- stalled slave: BEAT entered at the first edge (count 0),
        // count reaches 255 after 255 more edges, err registered on the
        // next edge, i.e. seen at the 257th falling edge of the burst ----
        slv_silent = 1'b1;
        do_burst(32'h0000_0700, 1'b0, 10'd4, 4'hF, 400);
        slv_silent = 1'b0;
        chk("tmo_err", {n_err[7:0], 7'd0, errlack}, 16'h0101);
        chk("tmo_nack", n_ack, 0);
        chk("tmo_latency", ncyc, 257);
        chk("tmo_cyc_low", cyc_after, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
